// File: rtl/monopulse_framer_if.sv
// Framed word stream from monopulse_framer to the feature-extraction block.
// Valid/ready handshake; the word moves on a clock edge with both high.
interface monopulse_framer_if;
   logic        Frame_valid;
   logic        Frame_ready;
   logic [15:0] Frame_data;
   logic        Frame_start;
   logic        Frame_last;
   logic        Trunc;

   modport master (
      output Frame_valid,
      output Frame_data,
      output Frame_start,
      output Frame_last,
      output Trunc,
      input  Frame_ready
   );

   modport slave (
      input  Frame_valid,
      input  Frame_data,
      input  Frame_start,
      input  Frame_last,
      input  Trunc,
      output Frame_ready
   );
endinterface

// File: rtl/monopulse_framer.sv
// Captures one above-threshold pulse into a buffer, then emits it as a
// header word (sample count) followed by zero-extended sample words.
module monopulse_framer #(
   parameter int MAX_LEN = 250,
   parameter int MIN_LEN = 4
) (
   input  logic                Clk_arithmetic,
   input  logic                Rst,
   input  logic                Adc_valid,
   input  logic [7:0]          Adc_data,
   input  logic [7:0]          Threshold,
   monopulse_framer_if.master  frm,
   output logic                Busy,
   output logic [15:0]         Drop_cnt
);

   localparam int LW = $clog2(MAX_LEN + 1);

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      HEADER,
      PAYLOAD
   } state_t;

   state_t          state_q, state_d;
   logic [LW-1:0]   len_q, len_d;
   logic [LW-1:0]   idx_q, idx_d;
   logic            armed_q, armed_d;
   logic            trunc_q, trunc_d;
   logic [15:0]     drop_q, drop_d;

   logic [7:0]      buf_q [MAX_LEN];
   logic [7:0]      rd_q;
   logic            wr_en;
   logic [LW-1:0]   wr_addr;
   logic            rd_en;
   logic [LW-1:0]   rd_addr;

   logic            above;
   logic            below;
   logic            xfer;
   logic            sending;
   logic [LW-1:0]   last_idx;

   assign above    = Adc_valid && (Adc_data > Threshold);
   assign below    = Adc_valid && (Adc_data <= Threshold);
   assign sending  = (state_q == HEADER) || (state_q == PAYLOAD);
   assign xfer     = sending && frm.Frame_ready;
   assign last_idx = len_q - 1'b1;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      armed_d = armed_q;
      trunc_d = trunc_q;
      drop_d  = drop_q;
      wr_en   = 1'b0;
      wr_addr = len_q;
      rd_en   = 1'b0;
      rd_addr = '0;

      if (below) begin
         armed_d = 1'b1;
      end

      // A pulse arriving while a frame is out is lost and counted.
      if (sending && above && armed_q) begin
         armed_d = 1'b0;
         if (drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
         end
      end

      unique case (state_q)
         IDLE: begin
            if (above && armed_q) begin
               wr_en   = 1'b1;
               wr_addr = '0;
               len_d   = LW'(1);
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            if (above) begin
               wr_en = 1'b1;
               len_d = len_q + 1'b1;
               if (len_q == LW'(MAX_LEN - 1)) begin
                  state_d = HEADER;
                  trunc_d = 1'b1;
                  armed_d = 1'b0;
                  rd_en   = 1'b1;
               end
            end else if (below) begin
               if (len_q >= LW'(MIN_LEN)) begin
                  state_d = HEADER;
                  rd_en   = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         HEADER: begin
            if (xfer) begin
               state_d = PAYLOAD;
               idx_d   = '0;
            end
         end
         PAYLOAD: begin
            if (xfer) begin
               if (idx_q == last_idx) begin
                  state_d = IDLE;
                  trunc_d = 1'b0;
               end else begin
                  // Prefetch the next word so there is no bubble.
                  idx_d   = idx_q + 1'b1;
                  rd_en   = 1'b1;
                  rd_addr = idx_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk_arithmetic) begin
      if (Rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         armed_q <= 1'b0;
         trunc_q <= 1'b0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         armed_q <= armed_d;
         trunc_q <= trunc_d;
         drop_q  <= drop_d;
      end
   end

   always_ff @(posedge Clk_arithmetic) begin
      if (wr_en) begin
         buf_q[wr_addr] <= Adc_data;
      end
      if (rd_en) begin
         rd_q <= buf_q[rd_addr];
      end
   end

   always_comb begin
      frm.Frame_valid = sending;
      frm.Frame_data  = 16'h0000;
      frm.Frame_start = 1'b0;
      frm.Frame_last  = 1'b0;
      frm.Trunc       = trunc_q;
      Busy            = (state_q != IDLE);
      Drop_cnt        = drop_q;
      unique case (state_q)
         HEADER: begin
            frm.Frame_data  = 16'(len_q);
            frm.Frame_start = 1'b1;
         end
         PAYLOAD: begin
            frm.Frame_data = {8'h00, rd_q};
            frm.Frame_last = (idx_q == last_idx);
         end
         default: ;
      endcase
   end

endmodule
